// File: rtl/pid_controller.sv
// pid_controller: discrete PD velocity regulator with an optional integral term.
// Each accepted enable runs one IDLE -> CALC -> UPDATE pass and moves the
// registered velocity command by the arithmetically shifted, clamped correction.
// Optional feature macro: PID_INTEGRAL_EN (adds a saturating 16-bit integrator).
// Handshake: en is a level request; it is accepted only in IDLE, and an accepted
// request always runs to completion (mid-pass input changes are ignored).
module pid_controller #(
    parameter logic [8:0] TARGET_VEL = 9'd200,
    parameter int         OUT_SHIFT  = 4,
    parameter int         KI_SHIFT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] current_vel,
    input  logic [7:0] KpKd,
    input  logic       en,
    output logic [8:0] vel_output
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured inputs for the pass in flight
    logic [8:0] cv_q, cv_d;
    logic [3:0] kp_q, kp_d;
    logic [3:0] kd_q, kd_d;

    // Registered error terms and products
    logic signed [9:0]  e_q, e_d;
    logic signed [9:0]  e_prev_q, e_prev_d;
    logic signed [15:0] p_q, p_d;
    logic signed [15:0] d_q, d_d;

    // Velocity command
    logic [8:0] vel_q, vel_d;

    // Combinational datapath
    logic signed [9:0]  e_calc;
    logic signed [10:0] de_calc;
    logic signed [15:0] p_calc;
    logic signed [15:0] d_calc;
    logic signed [15:0] i_term;
    logic signed [19:0] sum_w;
    logic signed [19:0] corr;
    logic signed [20:0] vel_sum;
    logic [8:0]         vel_clamped;

`ifdef PID_INTEGRAL_EN
    logic signed [15:0] acc_q, acc_d;
    logic signed [16:0] acc_sum;
    logic signed [15:0] acc_new;

    // Integrator: add the registered error, saturate symmetrically to +/-32767
    always_comb begin
        acc_sum = {acc_q[15], acc_q} + {{7{e_q[9]}}, e_q};
        if (acc_sum > 17'sd32767) begin
            acc_new = 16'sd32767;
        end else if (acc_sum < -17'sd32767) begin
            acc_new = -16'sd32767;
        end else begin
            acc_new = acc_sum[15:0];
        end
        i_term = acc_new >>> KI_SHIFT;
    end
`else
    // PD build: the integral contribution is identically zero
    always_comb begin
        i_term = 16'sd0 >>> KI_SHIFT;
    end
`endif

    // Error, products, correction and clamped next velocity
    always_comb begin
        e_calc  = $signed({1'b0, TARGET_VEL}) - $signed({1'b0, cv_q});
        de_calc = {e_calc[9], e_calc} - {e_prev_q[9], e_prev_q};
        p_calc  = $signed({12'd0, kp_q}) * $signed({{6{e_calc[9]}}, e_calc});
        d_calc  = $signed({12'd0, kd_q}) * $signed({{5{de_calc[10]}}, de_calc});
        sum_w   = {{4{p_q[15]}}, p_q} + {{4{d_q[15]}}, d_q} + {{4{i_term[15]}}, i_term};
        // Arithmetic shift floors toward minus infinity
        corr    = sum_w >>> OUT_SHIFT;
        vel_sum = $signed({12'd0, vel_q}) + $signed({corr[19], corr});
        if (vel_sum < 21'sd0) begin
            vel_clamped = 9'd0;
        end else if (vel_sum > 21'sd511) begin
            vel_clamped = 9'd511;
        end else begin
            vel_clamped = vel_sum[8:0];
        end
    end

    // Next-state and register-update logic for the three-phase pass
    always_comb begin
        state_d  = state_q;
        cv_d     = cv_q;
        kp_d     = kp_q;
        kd_d     = kd_q;
        e_d      = e_q;
        e_prev_d = e_prev_q;
        p_d      = p_q;
        d_d      = d_q;
        vel_d    = vel_q;
`ifdef PID_INTEGRAL_EN
        acc_d    = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    cv_d    = current_vel;
                    kp_d    = KpKd[7:4];
                    kd_d    = KpKd[3:0];
                    state_d = CALC;
                end
            end
            CALC: begin
                e_d     = e_calc;
                p_d     = p_calc;
                d_d     = d_calc;
                state_d = UPDATE;
            end
            UPDATE: begin
                vel_d    = vel_clamped;
                e_prev_d = e_q;
`ifdef PID_INTEGRAL_EN
                acc_d    = acc_new;
`endif
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any pass in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cv_q     <= '0;
            kp_q     <= '0;
            kd_q     <= '0;
            e_q      <= '0;
            e_prev_q <= '0;
            p_q      <= '0;
            d_q      <= '0;
            vel_q    <= '0;
`ifdef PID_INTEGRAL_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cv_q     <= cv_d;
            kp_q     <= kp_d;
            kd_q     <= kd_d;
            e_q      <= e_d;
            e_prev_q <= e_prev_d;
            p_q      <= p_d;
            d_q      <= d_d;
            vel_q    <= vel_d;
`ifdef PID_INTEGRAL_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign vel_output = vel_q;

endmodule

// File: tb/tb_pid_controller.sv
// tb_pid_controller: directed and randomized checks of pid_controller against
// an independent integer model of the regulator.
module tb_pid_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] current_vel;
    logic [7:0] KpKd;
    logic       en;
    logic [8:0] vel_output;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];

    // Reference model state
    int m_vel   = 0;
    int m_eprev = 0;
    int m_acc   = 0;

    // Clock: 10 ns period
    always #5 clk = ~clk;

    pid_controller dut (
        .clk         (clk),
        .rst         (rst),
        .current_vel (current_vel),
        .KpKd        (KpKd),
        .en          (en),
        .vel_output  (vel_output)
    );

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_vel   = 0;
        m_eprev = 0;
        m_acc   = 0;
        exp_q.delete();
    endtask

    // Predict the command after one update with these inputs and queue it
    task automatic model_push(input logic [8:0] cv, input logic [7:0] g);
        int e, de, sum, corr, nv, iterm;
        e     = 200 - int'(cv);
        de    = e - m_eprev;
        iterm = 0;
`ifdef PID_INTEGRAL_EN
        m_acc = m_acc + e;
        if (m_acc > 32767) m_acc = 32767;
        if (m_acc < -32767) m_acc = -32767;
        iterm = floor_div(m_acc, 8);
`endif
        sum  = int'(g[7:4]) * e + int'(g[3:0]) * de + iterm;
        corr = floor_div(sum, 16);
        nv   = m_vel + corr;
        if (nv < 0) nv = 0;
        if (nv > 511) nv = 511;
        m_vel   = nv;
        m_eprev = e;
        exp_q.push_back(nv[8:0]);
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] expv;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s expected queue empty observed=%0d", tag, vel_output);
        end else begin
            expv = exp_q.pop_front();
            check(tag, vel_output, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check("reset", vel_output, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // n back-to-back updates with en held high; checks hold on the two
    // intermediate edges and the new value on every third edge
    task automatic run_updates(input logic [8:0] cv, input logic [7:0] g, input int n, input string tag);
        logic [8:0] hold;
        @(negedge clk);
        current_vel = cv;
        KpKd        = g;
        en          = 1'b1;
        for (int u = 0; u < n; u++) begin
            hold = m_vel[8:0];
            model_push(cv, g);
            @(posedge clk);
            #1;
            check({tag, "_cap"}, vel_output, hold);
            @(posedge clk);
            #1;
            check({tag, "_calc"}, vel_output, hold);
            @(posedge clk);
            #1;
            pop_check(tag);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    // Single-cycle en pulse; inputs are scrambled after capture and must be ignored
    task automatic pulse_update(input logic [8:0] cv, input logic [7:0] g, input string tag);
        logic [8:0] hold;
        @(negedge clk);
        current_vel = cv;
        KpKd        = g;
        en          = 1'b1;
        hold        = m_vel[8:0];
        model_push(cv, g);
        @(posedge clk);
        #1;
        check({tag, "_cap"}, vel_output, hold);
        @(negedge clk);
        en          = 1'b0;
        current_vel = 9'($urandom_range(0, 511));
        KpKd        = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        check({tag, "_calc"}, vel_output, hold);
        @(posedge clk);
        #1;
        pop_check(tag);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_idle"}, vel_output, m_vel[8:0]);
        end
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        current_vel = '0;
        KpKd        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_init", vel_output, 9'd0);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Nominal run: 140, 252, 364, 476, then saturated at 511
        run_updates(9'd50, 8'hC3, 6, "s1");

        // Overspeed drives the command against the lower clamp
        do_reset();
        run_updates(9'd300, 8'hC0, 3, "over");

        // Latency/cadence with single pulses, including a negative correction
        do_reset();
        pulse_update(9'd100, 8'h52, "pulse_a");
        pulse_update(9'd250, 8'h52, "pulse_b");

        // Reset while CALC is in progress discards the pending update
        do_reset();
        run_updates(9'd50, 8'hC3, 2, "pre_rst");
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_calc", vel_output, 9'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_no_pending", vel_output, 9'd0);
        end
        run_updates(9'd50, 8'hC3, 1, "post_rst");

        // Zero gains hold the command
        do_reset();
        pulse_update(9'd50, 8'hC3, "zero_pre");
        for (int k = 0; k < 10; k++) begin
            run_updates(9'($urandom_range(0, 511)), 8'h00, 1, "zero");
        end

        // Random inputs against the model
        do_reset();
        for (int k = 0; k < 25; k++) begin
            run_updates(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
                        int'($urandom_range(1, 2)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
